image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/image_loader.sv | 166 ++++++++++++++++
 tb/tb_image_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Raster-order frame loader: accepts h*w pixel beats and writes them to image memory.
// Optional overrun flag enabled by defining LOADER_OVERRUN_ERR_EN.
module image_loader #(
    parameter int unsigned WORD  = 8,
    parameter int unsigned MAX_N = 25
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] h,
    input  logic [WORD-1:0] w,
    input  logic            start,
    input  logic            in_valid,
    input  logic [WORD-1:0] in_data,
    output logic            in_ready,
    output logic [WORD:0]   w_addr,
    output logic [WORD-1:0] w_data,
    output logic            w_en,
    output logic [WORD-1:0] lines_done,
    output logic            frame_done,
    output logic            busy,
    output logic            err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Kernel size is shared across the family but has no role in this block.
    logic unused_max_n;
    assign unused_max_n = ^MAX_N;

    logic [1:0]      state_q, state_d;
    logic [WORD-1:0] h_q, h_d;
    logic [WORD-1:0] w_q, w_d;
    logic [WORD:0]   addr_q, addr_d;
    logic [WORD-1:0] row_q, row_d;
    logic [WORD-1:0] col_q, col_d;
    logic [WORD-1:0] lines_q, lines_d;
    logic [WORD:0]   w_addr_q, w_addr_d;
    logic [WORD-1:0] w_data_q, w_data_d;
    logic            w_en_q, w_en_d;

    logic start_ok;
    logic last_col;
    logic last_row;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_col = (col_q == w_q - WORD'(1));
    assign last_row = (row_q == h_q - WORD'(1));

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        w_d      = w_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        lines_d  = lines_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        w_en_d   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    addr_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    lines_d = '0;
                    if ((h != '0) && (w != '0)) begin
                        state_d = StLoad;
                        h_d     = h;
                        w_d     = w;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    w_en_d   = 1'b1;
                    w_addr_d = addr_q;
                    w_data_d = in_data;
                    addr_d   = addr_q + (WORD+1)'(1);
                    if (last_col) begin
                        col_d   = '0;
                        row_d   = row_q + WORD'(1);
                        lines_d = lines_q + WORD'(1);
                        if (last_row) begin
                            state_d = StFlush;
                        end
                    end else begin
                        col_d = col_q + WORD'(1);
                    end
                end
            end
            StFlush: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            h_q      <= '0;
            w_q      <= '0;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            lines_q  <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_en_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            w_q      <= w_d;
            addr_q   <= addr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            lines_q  <= lines_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            w_en_q   <= w_en_d;
        end
    end

`ifdef LOADER_OVERRUN_ERR_EN
    logic err_q, err_d;

    // A beat offered while not loading sets the flag even if start clears it the same cycle.
    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        if (in_valid && (state_q != StLoad)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign err = 1'b0;
`endif

    assign in_ready   = (state_q == StLoad);
    assign busy       = (state_q == StLoad) || (state_q == StFlush);
    assign frame_done = (state_q == StDone);
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign w_en       = w_en_q;
    assign lines_done = lines_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: expected writes are queued as beats are driven
// and checked by a negedge monitor whenever w_en is seen.
module tb_image_loader;

    localparam int WORD = 8;
`ifdef LOADER_OVERRUN_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [WORD-1:0] h;
    logic [WORD-1:0] w;
    logic            start;
    logic            in_valid;
    logic [WORD-1:0] in_data;
    logic            in_ready;
    logic [WORD:0]   w_addr;
    logic [WORD-1:0] w_data;
    logic            w_en;
    logic [WORD-1:0] lines_done;
    logic            frame_done;
    logic            busy;
    logic            err;

    image_loader #(.WORD(WORD), .MAX_N(25)) dut (
        .clk        (clk),
        .rst        (rst),
        .h          (h),
        .w          (w),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_en       (w_en),
        .lines_done (lines_done),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD:0]   addr;
        logic [WORD-1:0] data;
        logic [WORD-1:0] lines;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  compared   = 0;
    int  mismatched = 0;

    logic [WORD:0]   model_addr;
    logic [WORD-1:0] model_lines;
    int              model_col;
    int              model_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int hh, input int ww);
        h     = WORD'(hh);
        w     = WORD'(ww);
        start = 1'b1;
        step();
        start       = 1'b0;
        model_addr  = '0;
        model_lines = '0;
        model_col   = 0;
        model_w     = ww;
    endtask

    task automatic beat(input logic [WORD-1:0] d);
        wr_t e;
        in_valid = 1'b1;
        in_data  = d;
        if (model_col == model_w - 1) begin
            model_col   = 0;
            model_lines = model_lines + 1'b1;
        end else begin
            model_col++;
        end
        e.addr  = model_addr;
        e.data  = d;
        e.lines = model_lines;
        exp_q.push_back(e);
        model_addr = model_addr + 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(w_addr), 32'h1ff0_0000);
            end else begin
                mon_e = exp_q.pop_front();
                chk("w_addr", 32'(w_addr), 32'(mon_e.addr));
                chk("w_data", 32'(w_data), 32'(mon_e.data));
                chk("lines_at_write", 32'(lines_done), 32'(mon_e.lines));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        h        = '0;
        w        = '0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_lines", 32'(lines_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Reset wins over start.
        h     = 8'd2;
        w     = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Zero-height frame goes straight to DONE without writes.
        begin_frame(0, 5);
        chk("h0_frame_done", 32'(frame_done), 32'd1);
        chk("h0_busy", 32'(busy), 32'd0);
        chk("h0_lines", 32'(lines_done), 32'd0);
        step();

        // 3x4 frame, back-to-back beats.
        begin_frame(3, 4);
        chk("f34_frame_done_clr", 32'(frame_done), 32'd0);
        chk("f34_in_ready", 32'(in_ready), 32'd1);
        chk("f34_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            beat(WORD'(i));
        end
        chk("f34_flush_frame_done", 32'(frame_done), 32'd0);
        chk("f34_flush_w_en", 32'(w_en), 32'd1);
        chk("f34_flush_in_ready", 32'(in_ready), 32'd0);
        chk("f34_flush_busy", 32'(busy), 32'd1);
        step();
        chk("f34_frame_done", 32'(frame_done), 32'd1);
        chk("f34_busy_done", 32'(busy), 32'd0);
        chk("f34_lines", 32'(lines_done), 32'd3);
        chk("f34_queue_empty", 32'(exp_q.size()), 32'd0);

        // Start raised mid-load is ignored; new h/w must not be latched.
        begin_frame(3, 4);
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) begin
                h     = 8'd1;
                w     = 8'd1;
                start = 1'b1;
            end
            beat(WORD'(8'h40 + i));
            start = 1'b0;
            if (i == 6) begin
                chk("mid_start_busy", 32'(busy), 32'd1);
                chk("mid_start_lines", 32'(lines_done), 32'd1);
            end
        end
        step();
        chk("mid_start_frame_done", 32'(frame_done), 32'd1);
        chk("mid_start_lines_end", 32'(lines_done), 32'd3);

        // 2x2 frame with gaps between beats.
        begin_frame(2, 2);
        for (int i = 0; i < 4; i++) begin
            beat(WORD'(8'hA0 + i));
            if (i < 3) begin
                step();
                chk("gap_w_en", 32'(w_en), 32'd0);
                chk("gap_frame_done", 32'(frame_done), 32'd0);
            end
        end
        chk("gap_last_w_en", 32'(w_en), 32'd1);
        step();
        chk("gap_frame_done_end", 32'(frame_done), 32'd1);
        chk("gap_lines", 32'(lines_done), 32'd2);

        // Stray beat while DONE.
        in_valid = 1'b1;
        in_data  = 8'd99;
        step();
        in_valid = 1'b0;
        chk("overrun_err", 32'(err), 32'(ERR_EN));
        step();
        chk("overrun_err_sticky", 32'(err), 32'(ERR_EN));
        chk("overrun_frame_done", 32'(frame_done), 32'd1);
        begin_frame(1, 1);
        chk("start_clears_err", 32'(err), 32'd0);
        chk("start_1x1_busy", 32'(busy), 32'd1);
        beat(8'd7);
        step();
        chk("f11_frame_done", 32'(frame_done), 32'd1);

        // Reset in the middle of a frame abandons it.
        begin_frame(3, 4);
        for (int i = 1; i <= 5; i++) begin
            beat(WORD'(8'h20 + i));
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd55;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_w_en", 32'(w_en), 32'd0);
        chk("midrst_w_addr", 32'(w_addr), 32'd0);
        chk("midrst_lines", 32'(lines_done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        step();
        step();
        step();
        begin_frame(1, 2);
        beat(8'h31);
        beat(8'h32);
        step();
        chk("reload_frame_done", 32'(frame_done), 32'd1);
        chk("reload_lines", 32'(lines_done), 32'd1);
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
